// File: rtl/detection_pkg.sv
// detection_pkg: shared state encoding and sizing constants for the
// face-detection sequencing logic.
`default_nettype none

package detection_pkg;

  localparam int ADDR_W      = 15;
  localparam int FRAME_WORDS = 19200;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DETECT  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/detection_fsm.sv
// detection_fsm: arms one frame capture per user request, then runs the classifier
// cascade; owns the port-A address/write-enable mux of the integral-image BRAM.
`default_nettype none

module detection_fsm #(
  parameter int ADDR_W = detection_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_done,
  input  logic              detect_done,
  // 'continue' is a reserved word in SystemVerilog, hence the suffix
  input  logic              continue_req,
  input  logic              write_en_in,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] classifier_rd_addr,
  output logic              detect_en,
  output logic [ADDR_W-1:0] address_a_out,
  output logic              write_en_out,
  output logic [1:0]        state_out
);

  import detection_pkg::*;

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_CAPTURE = ST_CAPTURE;
  localparam logic [1:0] S_DETECT  = ST_DETECT;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       cap_done_q;
  logic       cap_rise;

  // Only a fresh rising edge ends capture; a level already high on entry is ignored.
  assign cap_rise = cap_done & ~cap_done_q;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (continue_req) state_next = S_CAPTURE;
      S_CAPTURE: if (cap_rise)     state_next = S_DETECT;
      S_DETECT:  if (detect_done)  state_next = S_IDLE;
      default:                     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cap_done_q <= 1'b0;
    end else begin
      state      <= state_next;
      cap_done_q <= cap_done;
    end
  end

  // Capture owns port A only while capturing; otherwise the cascade reads and the
  // buffer stays frozen so the last frame is preserved.
  always_comb begin
    address_a_out = classifier_rd_addr;
    write_en_out  = 1'b0;
    detect_en     = 1'b0;
    case (state)
      S_CAPTURE: begin
        address_a_out = wr_addr;
        write_en_out  = write_en_in;
      end
      S_DETECT: detect_en = 1'b1;
      default: ;
    endcase
  end

  assign state_out = state;

endmodule

`default_nettype wire

// File: tb/tb_detection_fsm.sv
// tb_detection_fsm: directed steps from the test plan followed by randomized
// stimulus, all checked against a behavioural run/phase model.
`default_nettype none

module tb_detection_fsm;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cap_done = 1'b0;
  logic          detect_done = 1'b0;
  logic          continue_req = 1'b0;
  logic          write_en_in = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] classifier_rd_addr = '0;
  logic          detect_en;
  logic [AW-1:0] address_a_out;
  logic          write_en_out;
  logic [1:0]    state_out;

  int tests  = 0;
  int failed = 0;

  // Reference model: which phase of a run we are in, and the last sampled cap_done.
  int m_phase = 0;     // 0 idle, 1 capturing, 2 detecting
  bit m_cap_prev = 0;

  detection_fsm #(.ADDR_W(AW)) dut (
    .clk                (clk),
    .rst                (rst),
    .cap_done           (cap_done),
    .detect_done        (detect_done),
    .continue_req       (continue_req),
    .write_en_in        (write_en_in),
    .wr_addr            (wr_addr),
    .classifier_rd_addr (classifier_rd_addr),
    .detect_en          (detect_en),
    .address_a_out      (address_a_out),
    .write_en_out       (write_en_out),
    .state_out          (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive inputs mid-cycle, then compare every output against the model.
  task automatic drive(input bit r, input bit c, input bit cd, input bit dd,
                       input bit we, input logic [AW-1:0] wa, input logic [AW-1:0] ca);
    @(negedge clk);
    rst = r; continue_req = c; cap_done = cd; detect_done = dd;
    write_en_in = we; wr_addr = wa; classifier_rd_addr = ca;
    #1;
    chk("model_state", {30'd0, state_out}, m_phase);
    chk("model_det", {31'd0, detect_en}, (m_phase == 2) ? 1 : 0);
    chk("model_we", {31'd0, write_en_out}, (m_phase == 1) ? we : 0);
    chk("model_addr", {17'd0, address_a_out}, (m_phase == 1) ? wa : ca);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_phase    = 0;
      m_cap_prev = 0;
    end else begin
      if (m_phase == 0 && continue_req)                 m_phase = 1;
      else if (m_phase == 1 && cap_done && !m_cap_prev) m_phase = 2;
      else if (m_phase == 2 && detect_done)             m_phase = 0;
      m_cap_prev = cap_done;
    end
  endtask

  initial begin
    // Reset with all inputs low; port A follows the classifier address.
    drive(1, 0, 0, 0, 0, 0, 15'h1234); tick();
    drive(0, 0, 0, 0, 0, 0, 15'h1234);
    chk("rst_state", {30'd0, state_out}, 0);
    chk("rst_det", {31'd0, detect_en}, 0);
    chk("rst_we", {31'd0, write_en_out}, 0);
    chk("rst_addr", {17'd0, address_a_out}, 32'h1234);
    tick();

    // Continue with cap_done already high: capture starts but that level cannot end it.
    drive(0, 1, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 1, 100, 0);
    chk("cap_state", {30'd0, state_out}, 1);
    chk("cap_addr", {17'd0, address_a_out}, 100);
    chk("cap_we", {31'd0, write_en_out}, 1);
    tick();
    drive(0, 0, 1, 0, 1, 101, 0);
    chk("cap_held_high", {30'd0, state_out}, 1);
    tick();
    drive(0, 0, 0, 0, 1, 102, 0); tick();
    drive(0, 0, 1, 0, 1, 103, 0);
    chk("cap_before_rise", {30'd0, state_out}, 1);
    tick();
    drive(0, 0, 0, 0, 1, 104, 9599);
    chk("det_state", {30'd0, state_out}, 2);
    chk("det_en", {31'd0, detect_en}, 1);
    chk("det_we_blocked", {31'd0, write_en_out}, 0);
    chk("det_addr", {17'd0, address_a_out}, 9599);
    tick();

    // Continue during detect is ignored; detect_done ends the run.
    drive(0, 1, 0, 0, 0, 0, 9599); tick();
    drive(0, 0, 0, 0, 0, 0, 9599);
    chk("det_ignore_cont", {30'd0, state_out}, 2);
    tick();
    drive(0, 0, 0, 1, 0, 0, 9599); tick();
    drive(0, 0, 0, 0, 0, 0, 9599);
    chk("done_state", {30'd0, state_out}, 0);
    chk("done_det", {31'd0, detect_en}, 0);
    tick();

    // cap_done pulse in idle is ignored.
    drive(0, 0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("idle_ignore_cap", {30'd0, state_out}, 0);
    tick();

    // Reset mid-capture aborts; a fresh continue starts a new run.
    drive(0, 1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rerun_cap", {30'd0, state_out}, 1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("abort_state", {30'd0, state_out}, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 7, 0);
    chk("restart_state", {30'd0, state_out}, 1);
    chk("restart_we", {31'd0, write_en_out}, 1);
    tick();

    // Randomized run against the model.
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(31) == 0), ($urandom_range(3) == 0), ($urandom_range(2) == 0),
            ($urandom_range(3) == 0), $urandom_range(1),
            AW'($urandom_range(19199)), AW'($urandom_range(19199)));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
